aes_pipe_ctrl: RTL and testbench

AES_PIPE_CTRL -- requirements
Module: aes_pipe_ctrl

---
 rtl/aes_pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_aes_pipe_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_pipe_ctrl.sv
// Control plane for a fully unrolled AES pipeline: key-expansion sequencing, input handshake and per-stage valids.
// Optional block tags ride along with the valids when AES_PIPE_TAG_EN is defined. fsm_state: IDLE=0 KEXP=1 RUN=2 DRAIN=3.
module aes_pipe_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_load,
    output logic                  key_ready,
    output logic                  kx_we,
    output logic [3:0]            kx_round,
    output logic [7:0]            kx_rcon,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NUM_ROUNDS:0]   round_en,
    output logic                  out_valid,
    output logic [4:0]            inflight,
`ifdef AES_PIPE_TAG_EN
    input  logic [3:0]            in_tag,
    output logic [3:0]            out_tag,
`endif
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t                state;
    state_t                state_next;
    logic [3:0]            kx_step;
    logic [3:0]            kx_step_next;
    logic [NUM_ROUNDS:0]   v;
    logic [4:0]            inflight_q;
    logic                  accept;
    logic [3:0]            rcon_idx;

    // Handshake: a block transfers on a rising edge where in_valid and in_ready are both high;
    // in_ready never depends on in_valid, and the pipeline never back-pressures once a block is in.
    always_comb begin
        state_next   = state;
        kx_step_next = kx_step;
        key_ready    = 1'b0;
        in_ready     = 1'b0;
        kx_we        = 1'b0;
        case (state)
            IDLE: begin
                if (key_load) begin
                    state_next   = KEXP;
                    kx_step_next = 4'd1;
                end
            end
            KEXP: begin
                kx_we = 1'b1;
                if (kx_step == LAST_ROUND) begin
                    state_next   = RUN;
                    kx_step_next = 4'd0;
                end else begin
                    kx_step_next = kx_step + 4'd1;
                end
            end
            RUN: begin
                key_ready = 1'b1;
                in_ready  = ~key_load;
                if (key_load) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_q == 5'd0) begin
                    state_next   = KEXP;
                    kx_step_next = 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            kx_step <= 4'd0;
        end else begin
            state   <= state_next;
            kx_step <= kx_step_next;
        end
    end

    assign accept    = in_valid & in_ready;
    assign fsm_state = state;
    assign kx_round  = kx_step;

    // AES-256 uses each round constant for two consecutive round keys.
    assign rcon_idx = (NUM_ROUNDS == 14) ? ((kx_step + 4'd1) >> 1) : kx_step;

    always_comb begin
        kx_rcon = 8'h00;
        if (kx_we) begin
            case (rcon_idx)
                4'd1:    kx_rcon = 8'h01;
                4'd2:    kx_rcon = 8'h02;
                4'd3:    kx_rcon = 8'h04;
                4'd4:    kx_rcon = 8'h08;
                4'd5:    kx_rcon = 8'h10;
                4'd6:    kx_rcon = 8'h20;
                4'd7:    kx_rcon = 8'h40;
                4'd8:    kx_rcon = 8'h80;
                4'd9:    kx_rcon = 8'h1B;
                4'd10:   kx_rcon = 8'h36;
                default: kx_rcon = 8'h00;
            endcase
        end
    end

    // The valid chain free-runs in every state so blocks finish under the keys they entered with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v          <= '0;
            inflight_q <= 5'd0;
        end else begin
            v          <= {v[NUM_ROUNDS-1:0], accept};
            inflight_q <= inflight_q + {4'd0, accept} - {4'd0, v[NUM_ROUNDS]};
        end
    end

    assign round_en  = {v[NUM_ROUNDS-1:0], accept};
    assign out_valid = v[NUM_ROUNDS];
    assign inflight  = inflight_q;

`ifdef AES_PIPE_TAG_EN
    logic [3:0] tag_pipe [NUM_ROUNDS+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                tag_pipe[i] <= 4'd0;
            end
        end else begin
            tag_pipe[0] <= accept ? in_tag : 4'd0;
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign out_tag = out_valid ? tag_pipe[NUM_ROUNDS] : 4'd0;
`endif

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Bench for aes_pipe_ctrl: a 10-round instance under directed and random traffic, plus a 14-round
// instance for the AES-256 key schedule; tag checks are active when AES_PIPE_TAG_EN is defined.
module tb_aes_pipe_ctrl;

    localparam int NR   = 10;
    localparam int NR14 = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          key_load = 1'b0;
    logic          in_valid = 1'b0;
    logic [3:0]    in_tag = 4'd0;
    logic          key_ready, kx_we, in_ready, out_valid;
    logic [3:0]    kx_round;
    logic [7:0]    kx_rcon;
    logic [NR:0]   round_en;
    logic [4:0]    inflight;
    logic [3:0]    out_tag;
    logic [1:0]    fsm_state;

    logic          key_load14 = 1'b0;
    logic          in_valid14 = 1'b0;
    logic [3:0]    in_tag14 = 4'd0;
    logic          key_ready14, kx_we14, in_ready14, out_valid14;
    logic [3:0]    kx_round14;
    logic [7:0]    kx_rcon14;
    logic [NR14:0] round_en14;
    logic [4:0]    inflight14;
    logic [3:0]    out_tag14;
    logic [1:0]    fsm_state14;

    always #5 clk = ~clk;

    aes_pipe_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_ready(key_ready),
        .kx_we(kx_we), .kx_round(kx_round), .kx_rcon(kx_rcon),
        .in_valid(in_valid), .in_ready(in_ready), .round_en(round_en),
        .out_valid(out_valid), .inflight(inflight),
`ifdef AES_PIPE_TAG_EN
        .in_tag(in_tag), .out_tag(out_tag),
`endif
        .fsm_state(fsm_state)
    );

    aes_pipe_ctrl #(.NUM_ROUNDS(NR14)) dut14 (
        .clk(clk), .rst(rst), .key_load(key_load14), .key_ready(key_ready14),
        .kx_we(kx_we14), .kx_round(kx_round14), .kx_rcon(kx_rcon14),
        .in_valid(in_valid14), .in_ready(in_ready14), .round_en(round_en14),
        .out_valid(out_valid14), .inflight(inflight14),
`ifdef AES_PIPE_TAG_EN
        .in_tag(in_tag14), .out_tag(out_tag14),
`endif
        .fsm_state(fsm_state14)
    );

`ifndef AES_PIPE_TAG_EN
    assign out_tag   = 4'd0;
    assign out_tag14 = 4'd0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 key expansion, 2 run, 3 drain; blocks kept as accept cycles.
    int ph = 0, ks = 0, ph14 = 0, ks14 = 0, cyc = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  exp_tag_q[$];
    logic        last_acc, last_ov;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    logic [3:0] tag_tab [3] = '{4'h3, 4'h7, 4'hA};

    int kxwe_cnt = 0, ov_cnt = 0, first_ov_cyc = -1, peak_infl = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic kl, input logic iv, input logic [3:0] tg);
        key_load = kl;
        in_valid = iv;
        in_tag   = tg;
    endtask

    task automatic reset_model();
        ph = 0; ks = 0; ph14 = 0; ks14 = 0;
        exp_q.delete();
        exp_tag_q.delete();
    endtask

    task automatic check_now();
        logic        exp_rdy;
        logic [NR:0] ren;
        int          age;
        exp_rdy  = (ph == 2) && !key_load;
        last_acc = exp_rdy && in_valid;
        ren      = '0;
        ren[0]   = last_acc;
        foreach (exp_q[j]) begin
            age = cyc - int'(exp_q[j]);
            if (age >= 1 && age <= NR) ren[age] = 1'b1;
        end
        last_ov = (exp_q.size() > 0) && (cyc - int'(exp_q[0]) == NR + 1);

        chk("fsm_state", 32'(fsm_state), 32'(ph));
        chk("key_ready", 32'(key_ready), 32'(ph == 2));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("kx_we", 32'(kx_we), 32'(ph == 1));
        chk("kx_round", 32'(kx_round), (ph == 1) ? 32'(ks) : 32'd0);
        chk("kx_rcon", 32'(kx_rcon), (ph == 1) ? 32'(rcon_tab[ks-1]) : 32'd0);
        chk("round_en", 32'(round_en), 32'(ren));
        chk("out_valid", 32'(out_valid), 32'(last_ov));
        chk("inflight", 32'(inflight), 32'(exp_q.size()));
`ifdef AES_PIPE_TAG_EN
        chk("out_tag", 32'(out_tag), last_ov ? 32'(exp_tag_q[0]) : 32'd0);
`endif
        chk("kx_we14", 32'(kx_we14), 32'(ph14 == 1));
        chk("kx_round14", 32'(kx_round14), (ph14 == 1) ? 32'(ks14) : 32'd0);
        chk("kx_rcon14", 32'(kx_rcon14), (ph14 == 1) ? 32'(rcon_tab[(ks14 + 1) / 2 - 1]) : 32'd0);
        chk("key_ready14", 32'(key_ready14), 32'(ph14 == 2));

        if (kx_we === 1'b1) kxwe_cnt++;
        if (out_valid === 1'b1) begin
            ov_cnt++;
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
        end
        if (int'(inflight) > peak_infl) peak_infl = int'(inflight);
    endtask

    task automatic advance();
        int infl;
        if (rst) begin
            reset_model();
        end else begin
            infl = exp_q.size();
            if (last_ov) begin
                void'(exp_q.pop_front());
                void'(exp_tag_q.pop_front());
            end
            if (last_acc) begin
                exp_q.push_back(32'(cyc));
                exp_tag_q.push_back(in_tag);
            end
            case (ph)
                0: if (key_load) begin ph = 1; ks = 1; end
                1: if (ks == NR) begin ph = 2; ks = 0; end else ks++;
                2: if (key_load) ph = 3;
                default: if (infl == 0) begin ph = 1; ks = 1; end
            endcase
            case (ph14)
                0: if (key_load14) begin ph14 = 1; ks14 = 1; end
                1: if (ks14 == NR14) begin ph14 = 2; ks14 = 0; end else ks14++;
                default: ;
            endcase
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input logic kl, input logic iv, input logic [3:0] tg);
        drive(kl, iv, tg);
        #3;
        check_now();
        advance();
    endtask

    task automatic wait_run(input string name);
        for (int i = 0; i < 60 && ph != 2; i++) run_cycle(1'b0, 1'b0, 4'd0);
        chk(name, 32'(key_ready), 32'd1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held: every output must read zero.
        run_cycle(1'b0, 1'b0, 4'd0);
        run_cycle(1'b1, 1'b1, 4'd0);
        rst = 1'b0;

        // Key expansion on both instances.
        key_load14 = 1'b1;
        drive(1'b1, 1'b0, 4'd0);
        #3;
        check_now();
        advance();
        key_load14 = 1'b0;
        kxwe_cnt = 0;
        repeat (NR) run_cycle(1'b0, 1'b0, 4'd0);
        chk("kexp_cycles", 32'(kxwe_cnt), 32'd10);
        run_cycle(1'b0, 1'b0, 4'd0);

        // 20-block burst.
        ov_cnt = 0; first_ov_cyc = -1; peak_infl = 0;
        begin
            int first_acc;
            first_acc = cyc;
            for (int i = 0; i < 20; i++)
                run_cycle(1'b0, 1'b1, (i < 3) ? tag_tab[i] : 4'($urandom_range(0, 15)));
            repeat (20) run_cycle(1'b0, 1'b0, 4'd0);
            chk("burst_latency", 32'(first_ov_cyc - first_acc), 32'd11);
        end
        chk("burst_out_count", 32'(ov_cnt), 32'd20);
        chk("burst_peak", 32'(peak_infl), 32'd11);
        chk("burst_empty", 32'(inflight), 32'd0);

        // Random traffic with occasional re-keying.
        for (int i = 0; i < 300; i++)
            run_cycle(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        // Re-key colliding with an offered block while three blocks are in flight.
        wait_run("wait_run_rekey");
        repeat (3) run_cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)));
        run_cycle(1'b1, 1'b1, 4'd5);
        repeat (21) run_cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)));

        // Asynchronous reset with five blocks in flight.
        wait_run("wait_run_reset");
        repeat (5) run_cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)));
        drive(1'b0, 1'b0, 4'd0);
        chk("pre_reset_inflight", 32'(inflight), 32'd5);
        #1;
        rst = 1'b1;
        #1;
        reset_model();
        check_now();
        advance();
        rst = 1'b0;
        repeat (15) run_cycle(1'b0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
